mtl_frame_writer: RTL and testbench

// - Write-side counterpart of the MTL display path: takes the RGB byte stream from the SPI slave
//   (PIC32 link), packs it into 32-bit pixel words and pushes them into the SDRAM write FIFO.
// - Drives oLoading, consumed as iLoading by the LCD controller (0 before load, 1 while loading, 0 when done).
// - Words are {8'h00,R,G,B}, the same layout the display path reads back (R=[23:16],G=[15:8],B=[7:0]).

---
 rtl/mtl_frame_writer.sv | 157 +++++++++++++++
 tb/tb_mtl_frame_writer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtl_frame_writer.sv
// Packs the SPI RGB byte stream into {8'h00,R,G,B} words for the SDRAM write FIFO.
// Optional byte checksum enabled by defining MTL_WRITER_CHECKSUM_EN.
module mtl_frame_writer #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 480,
  parameter int N_IMAGES = 1
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iSTART,
  input  logic [7:0]  iBYTE,
  input  logic        iBYTE_VALID,
  input  logic        iFIFO_FULL,
  output logic [31:0] oWRITE_DATA,
  output logic        oWRITE_SDRAM_EN,
  output logic        oLoading,
  output logic        oFrameDone,
  output logic [3:0]  oImageIdx,
  output logic        oOverrun,
  output logic [15:0] oChecksum
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t         state;
  state_t         state_next;
  logic [1:0]     phase;
  logic [7:0]     red;
  logic [7:0]     green;
  logic [23:0]    skid_data;
  logic           skid_valid;
  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic [3:0]     image;
  logic           last_seen;
  logic           overrun;
  logic           frame_done;

  logic loading;
  logic restart;
  logic accept;
  logic pixel_done;
  logic drain;
  logic finish;
  logic at_last;

  assign loading    = (state == LOAD);
  assign restart    = iSTART && !loading;
  assign accept     = loading && iBYTE_VALID && !last_seen;
  assign pixel_done = accept && (phase == 2'd2);
  assign drain      = loading && skid_valid && !iFIFO_FULL;
  // The skid always holds the final word once the last pixel is counted, so its drain ends the load.
  assign finish     = drain && last_seen;
  assign at_last    = (x == XW'(H_ACTIVE - 1)) && (y == YW'(V_ACTIVE - 1)) &&
                      (image == 4'(N_IMAGES - 1));

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (iSTART) state_next = LOAD;
      LOAD:    if (finish) state_next = DONE;
      DONE:    if (iSTART) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      phase      <= 2'd0;
      red        <= 8'h00;
      green      <= 8'h00;
      skid_data  <= 24'h0;
      skid_valid <= 1'b0;
      x          <= '0;
      y          <= '0;
      image      <= 4'd0;
      last_seen  <= 1'b0;
      overrun    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= finish;
      if (restart) begin
        phase      <= 2'd0;
        skid_valid <= 1'b0;
        x          <= '0;
        y          <= '0;
        image      <= 4'd0;
        last_seen  <= 1'b0;
        overrun    <= 1'b0;
      end else if (loading) begin
        if (accept) begin
          case (phase)
            2'd0:    begin red   <= iBYTE; phase <= 2'd1; end
            2'd1:    begin green <= iBYTE; phase <= 2'd2; end
            default: phase <= 2'd0;
          endcase
        end
        if (pixel_done) begin
          if (!skid_valid || drain) begin
            skid_data  <= {red, green, iBYTE};
            skid_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else if (drain) begin
          skid_valid <= 1'b0;
        end
        // Counters track completed pixels, dropped or not, so geometry survives an overrun.
        if (pixel_done) begin
          if (at_last) begin
            last_seen <= 1'b1;
          end else if (x == XW'(H_ACTIVE - 1)) begin
            x <= '0;
            if (y == YW'(V_ACTIVE - 1)) begin
              y     <= '0;
              image <= image + 4'd1;
            end else begin
              y <= y + 1'b1;
            end
          end else begin
            x <= x + 1'b1;
          end
        end
      end
    end
  end

`ifdef MTL_WRITER_CHECKSUM_EN
  logic [15:0] sum;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n)      sum <= 16'h0000;
    else if (restart) sum <= 16'h0000;
    else if (accept)  sum <= sum + {8'h00, iBYTE};
  end

  assign oChecksum = sum;
`else
  assign oChecksum = 16'h0000;
`endif

  assign oWRITE_DATA     = {8'h00, skid_data};
  assign oWRITE_SDRAM_EN = drain;
  assign oLoading        = loading;
  assign oFrameDone      = frame_done;
  assign oImageIdx       = image;
  assign oOverrun        = overrun;

endmodule

// File: tb/tb_mtl_frame_writer.sv
// Randomized self-checking bench for mtl_frame_writer on a 4x2 pixel, 2-image geometry.
module tb_mtl_frame_writer;

  localparam int H = 4;
  localparam int V = 2;
  localparam int N = 2;
  localparam int PIXELS = H * V * N;
`ifdef MTL_WRITER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        iCLK = 1'b0;
  logic        iRST_n;
  logic        iSTART;
  logic [7:0]  iBYTE;
  logic        iBYTE_VALID;
  logic        iFIFO_FULL;
  logic [31:0] oWRITE_DATA;
  logic        oWRITE_SDRAM_EN;
  logic        oLoading;
  logic        oFrameDone;
  logic [3:0]  oImageIdx;
  logic        oOverrun;
  logic [15:0] oChecksum;

  int total = 0;
  int bad = 0;
  logic [31:0] got[$];
  logic [31:0] exp_words[$];
  int done_cnt;
  int viol;

  mtl_frame_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .N_IMAGES(N)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iSTART(iSTART), .iBYTE(iBYTE),
    .iBYTE_VALID(iBYTE_VALID), .iFIFO_FULL(iFIFO_FULL),
    .oWRITE_DATA(oWRITE_DATA), .oWRITE_SDRAM_EN(oWRITE_SDRAM_EN),
    .oLoading(oLoading), .oFrameDone(oFrameDone), .oImageIdx(oImageIdx),
    .oOverrun(oOverrun), .oChecksum(oChecksum)
  );

  always #5 iCLK = ~iCLK;

  // Records every write strobe; strobes while the FIFO is full or outside a load are violations.
  always @(negedge iCLK) begin
    if (iRST_n) begin
      if (oWRITE_SDRAM_EN) begin
        got.push_back(oWRITE_DATA);
        if (iFIFO_FULL || !oLoading) viol++;
      end
      if (oFrameDone) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    iBYTE_VALID = 1'b1;
    iBYTE = b;
    tick();
    iBYTE_VALID = 1'b0;
  endtask

  task automatic start();
    iSTART = 1'b1;
    tick();
    iSTART = 1'b0;
  endtask

  task automatic clear_monitor();
    got.delete();
    exp_words.delete();
    done_cnt = 0;
    viol = 0;
  endtask

  task automatic do_reset();
    iRST_n = 1'b0;
    iSTART = 1'b0;
    iBYTE_VALID = 1'b0;
    iBYTE = 8'h00;
    iFIFO_FULL = 1'b0;
    ticks(2);
    iRST_n = 1'b1;
    tick();
    clear_monitor();
  endtask

  task automatic test_reset();
    iRST_n = 1'b0;
    iSTART = 1'b0;
    iBYTE_VALID = 1'b0;
    iBYTE = 8'h00;
    iFIFO_FULL = 1'b0;
    #3;
    total++; if (oWRITE_SDRAM_EN !== 1'b0) begin bad++; $display("FAIL reset_en: got %b want 0", oWRITE_SDRAM_EN); end
    total++; if (oWRITE_DATA !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", oWRITE_DATA); end
    total++; if (oLoading !== 1'b0) begin bad++; $display("FAIL reset_loading: got %b want 0", oLoading); end
    total++; if (oFrameDone !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", oFrameDone); end
    total++; if (oImageIdx !== 4'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", oImageIdx); end
    total++; if (oOverrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", oOverrun); end
    total++; if (oChecksum !== 16'h0) begin bad++; $display("FAIL reset_checksum: got %h want 0", oChecksum); end
    ticks(2);
    iRST_n = 1'b1;
    tick();
  endtask

  task automatic test_single_pixel();
    do_reset();
    start();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    total++; if (oWRITE_SDRAM_EN !== 1'b1) begin bad++; $display("FAIL single_strobe: got %b want 1", oWRITE_SDRAM_EN); end
    total++; if (oWRITE_DATA !== 32'h00112233) begin bad++; $display("FAIL single_data: got %h want 00112233", oWRITE_DATA); end
    total++; if (oLoading !== 1'b1) begin bad++; $display("FAIL single_loading: got %b want 1", oLoading); end
    tick();
    total++; if (got.size() !== 1) begin bad++; $display("FAIL single_count: got %0d want 1", got.size()); end
  endtask

  task automatic test_full_frame();
    logic [7:0] px[3];
    int sum;
    do_reset();
    start();
    sum = 0;
    for (int p = 0; p < PIXELS; p++) begin
      for (int k = 0; k < 3; k++) begin
        px[k] = 8'($urandom);
        sum += px[k];
        ticks($urandom_range(0, 2));
        send_byte(px[k]);
      end
      exp_words.push_back({8'h00, px[0], px[1], px[2]});
      if (p < PIXELS - 1) begin
        total++;
        if (oImageIdx !== 4'((p + 1) / (H * V))) begin
          bad++; $display("FAIL frame_idx[%0d]: got %0d want %0d", p, oImageIdx, (p + 1) / (H * V));
        end
      end
    end
    ticks(4);
    total++; if (got.size() !== PIXELS) begin bad++; $display("FAIL frame_count: got %0d want %0d", got.size(), PIXELS); end
    for (int i = 0; i < got.size() && i < exp_words.size(); i++) begin
      total++; if (got[i] !== exp_words[i]) begin bad++; $display("FAIL frame_word[%0d]: got %h want %h", i, got[i], exp_words[i]); end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL frame_done_pulses: got %0d want 1", done_cnt); end
    total++; if (oLoading !== 1'b0) begin bad++; $display("FAIL frame_loading: got %b want 0", oLoading); end
    total++; if (oOverrun !== 1'b0) begin bad++; $display("FAIL frame_overrun: got %b want 0", oOverrun); end
    total++; if (oChecksum !== (CK ? 16'(sum) : 16'h0)) begin bad++; $display("FAIL frame_checksum: got %h want %h", oChecksum, CK ? 16'(sum) : 16'h0); end
    total++; if (viol !== 0) begin bad++; $display("FAIL frame_illegal_strobes: got %0d want 0", viol); end
    // Bytes in DONE must be ignored and the checksum held.
    send_byte(8'h5A);
    send_byte(8'hA5);
    send_byte(8'h3C);
    ticks(3);
    total++; if (got.size() !== PIXELS) begin bad++; $display("FAIL done_ignore_count: got %0d want %0d", got.size(), PIXELS); end
    total++; if (oChecksum !== (CK ? 16'(sum) : 16'h0)) begin bad++; $display("FAIL done_checksum_hold: got %h want %h", oChecksum, CK ? 16'(sum) : 16'h0); end
  endtask

  task automatic test_backpressure();
    logic [7:0] px[3];
    logic [31:0] word;
    int hold;
    clear_monitor();
    start();
    total++; if (oOverrun !== 1'b0 || oLoading !== 1'b1) begin bad++; $display("FAIL restart_state: got overrun=%b loading=%b want 0/1", oOverrun, oLoading); end
    for (int p = 0; p < PIXELS; p++) begin
      for (int k = 0; k < 3; k++) px[k] = 8'($urandom);
      word = {8'h00, px[0], px[1], px[2]};
      exp_words.push_back(word);
      iFIFO_FULL = 1'($urandom_range(0, 1));
      send_byte(px[0]);
      iFIFO_FULL = 1'($urandom_range(0, 1));
      send_byte(px[1]);
      iFIFO_FULL = 1'b1;
      send_byte(px[2]);
      hold = (p == 0) ? 10 : $urandom_range(0, 4);
      ticks(hold);
      total++; if (got.size() !== p) begin bad++; $display("FAIL bp_held[%0d]: got %0d words want %0d", p, got.size(), p); end
      iFIFO_FULL = 1'b0;
      #1;
      total++; if (oWRITE_SDRAM_EN !== 1'b1) begin bad++; $display("FAIL bp_release_strobe[%0d]: got %b want 1", p, oWRITE_SDRAM_EN); end
      total++; if (oWRITE_DATA !== word) begin bad++; $display("FAIL bp_release_data[%0d]: got %h want %h", p, oWRITE_DATA, word); end
      tick();
    end
    ticks(3);
    total++; if (got.size() !== PIXELS) begin bad++; $display("FAIL bp_count: got %0d want %0d", got.size(), PIXELS); end
    for (int i = 0; i < got.size() && i < exp_words.size(); i++) begin
      total++; if (got[i] !== exp_words[i]) begin bad++; $display("FAIL bp_word[%0d]: got %h want %h", i, got[i], exp_words[i]); end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL bp_done_pulses: got %0d want 1", done_cnt); end
    total++; if (oOverrun !== 1'b0) begin bad++; $display("FAIL bp_overrun: got %b want 0", oOverrun); end
    total++; if (viol !== 0) begin bad++; $display("FAIL bp_illegal_strobes: got %0d want 0", viol); end
  endtask

  task automatic test_overrun();
    logic [7:0] px[3];
    int sum;
    do_reset();
    start();
    sum = 0;
    iFIFO_FULL = 1'b1;
    // First pixel parks in the skid, second is lost.
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 3; k++) begin
        px[k] = 8'($urandom);
        sum += px[k];
        send_byte(px[k]);
      end
      if (p == 0) exp_words.push_back({8'h00, px[0], px[1], px[2]});
    end
    total++; if (oOverrun !== 1'b1) begin bad++; $display("FAIL ovr_flag: got %b want 1", oOverrun); end
    total++; if (got.size() !== 0) begin bad++; $display("FAIL ovr_no_strobe: got %0d want 0", got.size()); end
    iFIFO_FULL = 1'b0;
    ticks(2);
    total++; if (got.size() !== 1) begin bad++; $display("FAIL ovr_first_issued: got %0d want 1", got.size()); end
    for (int p = 2; p < PIXELS; p++) begin
      for (int k = 0; k < 3; k++) begin
        px[k] = 8'($urandom);
        sum += px[k];
        send_byte(px[k]);
      end
      exp_words.push_back({8'h00, px[0], px[1], px[2]});
    end
    ticks(4);
    total++; if (got.size() !== PIXELS - 1) begin bad++; $display("FAIL ovr_count: got %0d want %0d", got.size(), PIXELS - 1); end
    for (int i = 0; i < got.size() && i < exp_words.size(); i++) begin
      total++; if (got[i] !== exp_words[i]) begin bad++; $display("FAIL ovr_word[%0d]: got %h want %h", i, got[i], exp_words[i]); end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL ovr_done_pulses: got %0d want 1", done_cnt); end
    total++; if (oLoading !== 1'b0) begin bad++; $display("FAIL ovr_loading: got %b want 0", oLoading); end
    total++; if (oOverrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got %b want 1", oOverrun); end
    total++; if (oChecksum !== (CK ? 16'(sum) : 16'h0)) begin bad++; $display("FAIL ovr_checksum: got %h want %h", oChecksum, CK ? 16'(sum) : 16'h0); end
    start();
    total++; if (oOverrun !== 1'b0) begin bad++; $display("FAIL ovr_cleared: got %b want 0", oOverrun); end
  endtask

  task automatic test_reset_midload();
    logic [7:0] px[3];
    do_reset();
    start();
    for (int k = 0; k < 5; k++) send_byte(8'($urandom));
    iRST_n = 1'b0;
    #1;
    total++; if (oLoading !== 1'b0 || oWRITE_SDRAM_EN !== 1'b0) begin bad++; $display("FAIL midrst_outputs: got loading=%b en=%b want 0/0", oLoading, oWRITE_SDRAM_EN); end
    tick();
    iRST_n = 1'b1;
    tick();
    clear_monitor();
    start();
    for (int k = 0; k < 3; k++) begin
      px[k] = 8'($urandom);
      send_byte(px[k]);
    end
    ticks(2);
    total++; if (got.size() !== 1) begin bad++; $display("FAIL midrst_count: got %0d want 1", got.size()); end
    if (got.size() > 0) begin
      total++; if (got[0] !== {8'h00, px[0], px[1], px[2]}) begin bad++; $display("FAIL midrst_word: got %h want %h", got[0], {8'h00, px[0], px[1], px[2]}); end
    end
  endtask

  task automatic test_start_with_byte();
    logic [7:0] px[3];
    do_reset();
    iSTART = 1'b1;
    iBYTE_VALID = 1'b1;
    iBYTE = 8'hAA;
    tick();
    iSTART = 1'b0;
    iBYTE_VALID = 1'b0;
    for (int k = 0; k < 3; k++) px[k] = 8'($urandom);
    send_byte(px[0]);
    iSTART = 1'b1;
    send_byte(px[1]);
    iSTART = 1'b0;
    send_byte(px[2]);
    ticks(2);
    total++; if (got.size() !== 1) begin bad++; $display("FAIL startbyte_count: got %0d want 1", got.size()); end
    if (got.size() > 0) begin
      total++; if (got[0] !== {8'h00, px[0], px[1], px[2]}) begin bad++; $display("FAIL startbyte_word: got %h want %h", got[0], {8'h00, px[0], px[1], px[2]}); end
    end
    total++; if (oChecksum !== (CK ? 16'(px[0] + px[1] + px[2]) : 16'h0)) begin
      bad++; $display("FAIL startbyte_checksum: got %h want %h", oChecksum, CK ? 16'(px[0] + px[1] + px[2]) : 16'h0);
    end
  endtask

  task automatic test_checksum();
    do_reset();
    start();
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'h02);
    tick();
    total++; if (oChecksum !== (CK ? 16'h0200 : 16'h0000)) begin bad++; $display("FAIL checksum: got %h want %h", oChecksum, CK ? 16'h0200 : 16'h0000); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    done_cnt = 0;
    viol = 0;
    test_reset();
    test_single_pixel();
    test_full_frame();
    test_backpressure();
    test_overrun();
    test_reset_midload();
    test_start_with_byte();
    test_checksum();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
